// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter: one shared multiplier steps through the taps,
// double-buffered coefficients, valid/ready input and a saturated output.
module fir_mac_seq #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned COEF_FRAC = 11,
  parameter int unsigned TAPS      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   x_in,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   y_out,
  output logic                       sat_flag
);

  localparam int unsigned AW     = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Output range limits held at accumulator width; ~max is the negative bound
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [DATA_W-1:0] x_dly  [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [PROD_W-1:0] prod;
  logic [AW-1:0]            idx;
  logic                     accept;
  logic                     addr_ok;
  logic                     idx_last;
  logic                     clamp_hi;
  logic                     clamp_lo;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign addr_ok  = {1'b0, coef_addr} < (AW + 1)'(TAPS);
  assign idx_last = (idx == AW'(TAPS - 1));

  // Shared MAC step and output scaling/clamp detection
  always_comb begin
    prod     = PROD_W'(active[idx]) * PROD_W'(x_dly[idx]);
    acc_sum  = acc + ACC_W'(prod);
    scaled   = acc >>> COEF_FRAC;
    clamp_hi = (scaled > Y_MAX);
    clamp_lo = (scaled < Y_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (idx_last) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath; the active bank copies the pre-edge shadow on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        x_dly[i]  <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (coef_we && addr_ok) shadow[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 1; i < int'(TAPS); i++) x_dly[i] <= x_dly[i-1];
            x_dly[0] <= x_in;
            for (int i = 0; i < int'(TAPS); i++) active[i] <= shadow[i];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + AW'(1);
        end
        OUT: begin
          if (clamp_hi)      y_out <= DATA_W'(Y_MAX);
          else if (clamp_lo) y_out <= DATA_W'(Y_MIN);
          else               y_out <= DATA_W'(scaled);
          sat_flag  <= clamp_hi || clamp_lo;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
